// File: rtl/reg_file_rename_if.sv
// -----------------------------------------------------------------------------
// reg_file_rename_if
//
// Purpose: bundles the traffic between the renaming register file and its
// neighbours. This covers the reorder buffer's issue stream (rd -> ROB id),
// its commit stream (rd/value write-back), the decoder's two source lookups,
// and the per-operand ROB bypass query.
//
// Modports:
//   master - the ROB/decoder side: drives issue, commit and lookup addresses,
//            answers the bypass query, and observes the operand results.
//   slave  - the register file: consumes requests and returns the operands
//            together with the bypass query tags.
// -----------------------------------------------------------------------------
interface reg_file_rename_if #(
  parameter int ROB_SIZE_WIDTH = 3
);

  // Rename (issue) stream from the reorder buffer.
  logic                      issue_valid;
  logic [4:0]                issue_rd;
  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id;

  // Write-back (commit) stream from the reorder buffer.
  logic                      commit_valid;
  logic [4:0]                commit_rd;
  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id;
  logic [31:0]               commit_value;

  // Decoder source-operand lookups.
  logic [4:0]                rs1_addr;
  logic [4:0]                rs2_addr;
  logic [31:0]               rs1_value;
  logic                      rs1_busy;
  logic [ROB_SIZE_WIDTH-1:0] rs1_rob_id;
  logic [31:0]               rs2_value;
  logic                      rs2_busy;
  logic [ROB_SIZE_WIDTH-1:0] rs2_rob_id;

  // Bypass query towards the ROB for results that exist but are not committed.
  logic [ROB_SIZE_WIDTH-1:0] rob_get_id1;
  logic [ROB_SIZE_WIDTH-1:0] rob_get_id2;
  logic                      rob_get_ready1;
  logic                      rob_get_ready2;
  logic [31:0]               rob_get_value1;
  logic [31:0]               rob_get_value2;

  modport master (
    output issue_valid, issue_rd, issue_rob_id,
    output commit_valid, commit_rd, commit_rob_id, commit_value,
    output rs1_addr, rs2_addr,
    input  rs1_value, rs1_busy, rs1_rob_id,
    input  rs2_value, rs2_busy, rs2_rob_id,
    input  rob_get_id1, rob_get_id2,
    output rob_get_ready1, rob_get_ready2, rob_get_value1, rob_get_value2
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rob_id,
    input  commit_valid, commit_rd, commit_rob_id, commit_value,
    input  rs1_addr, rs2_addr,
    output rs1_value, rs1_busy, rs1_rob_id,
    output rs2_value, rs2_busy, rs2_rob_id,
    output rob_get_id1, rob_get_id2,
    input  rob_get_ready1, rob_get_ready2, rob_get_value1, rob_get_value2
  );

endinterface : reg_file_rename_if

// File: rtl/reg_file_rename.sv
// -----------------------------------------------------------------------------
// reg_file_rename
//
// Purpose: architectural register file with per-register rename tags. It sits
// directly downstream of the reorder buffer. Each register holds a committed
// value, a busy flag and the ROB id of its youngest in-flight writer. The two
// source lookups are combinational. Each one returns either a usable value or
// the ROB id that will eventually produce it. A matching same-cycle commit, or
// a result the ROB already holds, is forwarded so that a value that already
// exists is never reported as pending.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset; overrides rdy and clear
//   rdy    - global enable; low freezes all state (lookups stay live)
//   clear  - misprediction flush: drops every pending mapping
//   bus    - reg_file_rename_if.slave carrying issue, commit, lookup and
//            ROB bypass query signals
// -----------------------------------------------------------------------------
module reg_file_rename #(
  parameter int ROB_SIZE_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  reg_file_rename_if.slave    bus
);

  localparam int NUM_REGS = 32;

  typedef logic [ROB_SIZE_WIDTH-1:0] tag_t;

  // Result of one source-operand lookup.
  typedef struct packed {
    logic [31:0] value;
    logic        busy;
    tag_t        rob_id;
  } lookup_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]         regs_q [NUM_REGS];
  logic [31:0]         regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  tag_t                tag_q  [NUM_REGS];
  tag_t                tag_d  [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Decoded request qualifiers. Writes to x0 are discarded here, so x0 stays
  // zero in the array and needs no special case on the write path.
  // ---------------------------------------------------------------------------
  logic commit_en;
  logic issue_en;

  assign commit_en = bus.commit_valid && (bus.commit_rd != 5'd0);
  assign issue_en  = bus.issue_valid  && (bus.issue_rd  != 5'd0) && !clear;

  // ---------------------------------------------------------------------------
  // Lookup. The result reflects the state after this cycle's commit but before
  // this cycle's issue. An instruction that renames the register it also reads
  // therefore sees the previous producer, not its own tag.
  // ---------------------------------------------------------------------------
  function automatic lookup_t lookup(
    input logic [4:0]  addr,
    input logic        get_ready,
    input logic [31:0] get_value
  );
    lookup_t res;
    res = '0;
    if (addr == 5'd0) begin
      res = '0;
    end else if (!busy_q[addr]) begin
      res.value = regs_q[addr];
    end else if (bus.commit_valid && (bus.commit_rd == addr) &&
                 (bus.commit_rob_id == tag_q[addr])) begin
      // The youngest writer is committing right now.
      res.value = bus.commit_value;
    end else if (get_ready) begin
      // The producer has finished but is still waiting in the ROB.
      res.value = get_value;
    end else begin
      res.busy   = 1'b1;
      res.rob_id = tag_q[addr];
    end
    return res;
  endfunction

  lookup_t rs1_res;
  lookup_t rs2_res;

  // NOTE: every variable written in an always_comb gets a default before any
  // branch. A path that leaves a variable unassigned infers a latch.
  always_comb begin
    rs1_res = lookup(bus.rs1_addr, bus.rob_get_ready1, bus.rob_get_value1);
    rs2_res = lookup(bus.rs2_addr, bus.rob_get_ready2, bus.rob_get_value2);
  end

  assign bus.rs1_value  = rs1_res.value;
  assign bus.rs1_busy   = rs1_res.busy;
  assign bus.rs1_rob_id = rs1_res.rob_id;
  assign bus.rs2_value  = rs2_res.value;
  assign bus.rs2_busy   = rs2_res.busy;
  assign bus.rs2_rob_id = rs2_res.rob_id;

  // The bypass query always carries the stored tag. The ROB answers it
  // whether or not the register is busy, and the lookup priority decides
  // whether that answer is used.
  assign bus.rob_get_id1 = tag_q[bus.rs1_addr];
  assign bus.rob_get_id2 = tag_q[bus.rs2_addr];

  // ---------------------------------------------------------------------------
  // Next-state. Statement order encodes the priority of the updates:
  //   1. Commit writes the value unconditionally. It releases busy only when
  //      its tag is still the youngest mapping. A mismatch means a younger
  //      writer is pending.
  //   2. Issue overrides busy/tag for the same register.
  //   3. Clear wipes every busy bit and suppresses issue. The commit value
  //      write still lands. Tags become don't-care and are left alone.
  // ---------------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;

    if (commit_en) begin
      regs_d[bus.commit_rd] = bus.commit_value;
      if (tag_q[bus.commit_rd] == bus.commit_rob_id) begin
        busy_d[bus.commit_rd] = 1'b0;
      end
    end

    if (clear) begin
      busy_d = '0;
    end else if (issue_en) begin
      busy_d[bus.issue_rd] = 1'b1;
      tag_d[bus.issue_rd]  = bus.issue_rob_id;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments. All registers then
  // sample their next values at the same instant, whatever the statement or
  // block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the value array is reset on purpose even though it is a memory.
      // A lookup of a non-busy register exposes its contents, so every
      // register must read a defined zero after reset.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
    end else if (rdy) begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

endmodule : reg_file_rename

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with rename tags; sits directly downstream of the reorder buffer.
- Consumes the reorder buffer's issue stream (rd to ROB id rename) and commit stream (rd/value write-back).
- Serves the decoder's two source-operand lookups combinationally. Each lookup returns either a ready value or the ROB id that will produce it.
- Forwards same-cycle commits and ROB-ready results so that an issuing instruction never waits on a value that already exists.

Parameters:
ROB_SIZE_WIDTH, 3, log2 of ROB entries; width of every rename tag.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
clear  in  1  misprediction flush from ROB
issue_valid  in  1  rename request this cycle
issue_rd  in  5  destination register being renamed
issue_rob_id  in  ROB_SIZE_WIDTH  ROB entry that will produce issue_rd
commit_valid  in  1  register write-back this cycle
commit_rd  in  5  register written by committing instruction
commit_rob_id  in  ROB_SIZE_WIDTH  ROB entry committing
commit_value  in  32  value written
rs1_addr  in  5  source register 1 lookup
rs2_addr  in  5  source register 2 lookup
rs1_value  out  32  operand 1 value (valid when rs1_busy=0)
rs1_busy  out  1  operand 1 still pending
rs1_rob_id  out  ROB_SIZE_WIDTH  producing ROB entry when rs1_busy=1, else 0
rs2_value  out  32  as rs1_value, for rs2
rs2_busy  out  1  as rs1_busy, for rs2
rs2_rob_id  out  ROB_SIZE_WIDTH  as rs1_rob_id, for rs2
rob_get_id1  out  ROB_SIZE_WIDTH  tag of rs1 sent to ROB for bypass query
rob_get_id2  out  ROB_SIZE_WIDTH  tag of rs2 sent to ROB for bypass query
rob_get_ready1  in  1  ROB reports rob_get_id1 result available
rob_get_ready2  in  1  ROB reports rob_get_id2 result available
rob_get_value1  in  32  value for rob_get_id1
rob_get_value2  in  32  value for rob_get_id2

Behaviour:
- State: 32 x 32-bit values; 32 busy bits; 32 tags of ROB_SIZE_WIDTH bits.
- Reset (rst=1 at posedge): all values 0, all busy 0, all tags 0. rst overrides rdy and clear.
- x0 rules:
  - x0 always reads value 0, busy 0.
  - Issue and commit targeting x0 are ignored; no state change.
- Lookups are purely combinational, zero latency, independent of rdy. For rsN = r, in priority order:
  1. r==0: value 0, busy 0, rob_id 0.
  2. busy[r]==0: value regs[r], busy 0, rob_id 0.
  3. commit_valid && commit_rd==r && commit_rob_id==tag[r]: value commit_value, busy 0.
  4. rob_get_readyN: value rob_get_valueN, busy 0.
  5. Otherwise: busy 1, rob_id tag[r], value 0.
- rob_get_idN = tag[rsN_addr] at all times.
- Lookups reflect state after this cycle's commit but before this cycle's issue. An instruction issuing with rd==rs1 sees the old mapping, not its own tag.
- Sequential update, gated on rdy=1:
  - Commit: if commit_valid && commit_rd!=0:
    - regs[commit_rd] <= commit_value, regardless of tag.
    - busy cleared only if tag[commit_rd]==commit_rob_id.
    - Tag mismatch: a younger writer is pending; busy and tag are kept.
  - Issue: if issue_valid && issue_rd!=0 && !clear: busy <= 1, tag <= issue_rob_id.
  - Same-cycle issue and commit to the same rd: issue wins for busy/tag; commit still writes the value.
  - Clear:
    - All 32 busy bits <= 0; tags unchanged (don't-care).
    - Any same-cycle commit value write is still applied.
    - Same-cycle issue is dropped.
- rdy=0: no state change; outputs still driven combinationally.
- Tag wrap-around: tags are compared for exact equality only. ROB-size reuse is safe because the ROB never holds two live entries with the same id.

Test Plan:
- Reset, then lookup x5 -> rs1_value 0, rs1_busy 0, rs1_rob_id 0.
- Issue rd=5 tag 3. Next cycle lookup x5 with rob_get_ready1=0 -> rs1_busy 1, rs1_rob_id 3, rob_get_id1 3. Then commit rd=5 tag 3 value 0x1234 -> same-cycle rs1_value 0x1234, busy 0; following cycle regs[5]=0x1234, busy 0.
- Issue rd=7 tag 1, then issue rd=7 tag 2, then commit rd=7 tag 1 value 0xAA -> regs[7]=0xAA but busy stays 1, rs1_rob_id 2. Commit tag 2 value 0xBB -> busy 0, value 0xBB.
- x7 busy with tag 4, rob_get_ready2=1, rob_get_value2=0x55, rs2_addr=7 -> rs2_value 0x55, rs2_busy 0, with no state change.
- x3, x4, x9 busy; assert clear with simultaneous commit rd=3 value 9 and issue rd=10 -> all busy 0, regs[3]=9, x10 not busy.
- Issue rd=0 and commit rd=0 value 0xFF -> x0 reads 0, busy 0. Repeat any issue with rdy=0 -> no state change.
